// File: rtl/checker_pkg.sv
// Shared mismatch codes and register-file packing helper for the lockstep checker.
// Register i of a packed file lives at [rf_lsb(i, XLEN) +: XLEN].
package checker_pkg;

    localparam logic [1:0] MISMATCH_NONE  = 2'd0;
    localparam logic [1:0] MISMATCH_PC    = 2'd1;
    localparam logic [1:0] MISMATCH_RF    = 2'd2;
    localparam logic [1:0] MISMATCH_PROTO = 2'd3;

    function automatic int rf_lsb(input int idx, input int xlen);
        return idx * xlen;
    endfunction

endpackage

// File: rtl/rf_diff_finder.sv
// Compares two packed register files; reports all-equal and the lowest
// differing register index (0 when the files are equal).
module rf_diff_finder
    import checker_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int XLEN     = 8,
    localparam int IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [NUM_REGS*XLEN-1:0] i_rf_a,
    input  logic [NUM_REGS*XLEN-1:0] i_rf_b,
    output logic                     o_all_eq,
    output logic [IW-1:0]            o_diff_idx
);

    // Scan downwards so the last hit is the lowest index.
    always_comb begin
        o_all_eq   = 1'b1;
        o_diff_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (i_rf_a[rf_lsb(i, XLEN) +: XLEN] !=
                i_rf_b[rf_lsb(i, XLEN) +: XLEN]) begin
                o_all_eq   = 1'b0;
                o_diff_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep equivalence checker: credit-driven ISA step enable, PC/RF compare.
// Define CHECKER_MISMATCH_LOG_EN to build the cycle counter and first-mismatch log.
module lockstep_checker
    import checker_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int XLEN        = 8,
    parameter int PC_W        = 8,
    parameter int COMMIT_W    = 2,
    parameter int PEND_MAX    = 8,
    parameter int STALL_LIMIT = 10,
    parameter int CYC_W       = 16,
    localparam int CW  = $clog2(COMMIT_W + 1),
    localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int STW = $clog2(STALL_LIMIT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CW-1:0]            i_dut_commit_cnt,
    output logic                     o_dut_hold,
    input  logic [PC_W-1:0]          i_dut_pc,
    input  logic [NUM_REGS*XLEN-1:0] i_dut_rf,
    output logic                     o_ref_step,
    input  logic [PC_W-1:0]          i_ref_pc,
    input  logic [NUM_REGS*XLEN-1:0] i_ref_rf,
    input  logic                     i_init_mem_same,
    output logic                     o_same_init_state,
    output logic                     o_incorrect,
    output logic                     o_live,
    output logic [STW-1:0]           o_stalled_cycle,
    output logic [1:0]               o_mismatch_kind,
    output logic [IW-1:0]            o_mismatch_reg,
    output logic [CYC_W-1:0]         o_mismatch_cycle
);

    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int SW = PW + CW + 1;

    logic [PW-1:0]  r_pend;
    logic           r_err;
    logic           r_init;
    logic [STW-1:0] r_stall;

    logic          w_step;
    logic          w_hold;
    logic          w_proto;
    logic [SW-1:0] w_sum;
    logic [PW-1:0] w_pend_nxt;
    logic          w_synced;
    logic          w_eq_pc;
    logic          w_eq_rf;
    logic          w_eq;
    logic [IW-1:0] w_diff_idx;
    logic          w_mismatch;
    logic          w_stall_clr;

    rf_diff_finder #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN)
    ) u_diff (
        .i_rf_a     (i_dut_rf),
        .i_rf_b     (i_ref_rf),
        .o_all_eq   (w_eq_rf),
        .o_diff_idx (w_diff_idx)
    );

    assign w_step = (r_pend != '0);
    // Hold when one more full-width retirement could overflow the credit.
    assign w_hold = (SW'(r_pend) - SW'(w_step) + SW'(COMMIT_W))
                    > SW'(PEND_MAX);
    assign w_proto = w_hold && (i_dut_commit_cnt != '0);

    assign w_sum = SW'(r_pend) + SW'(i_dut_commit_cnt) - SW'(w_step);
    assign w_pend_nxt = (w_sum > SW'(PEND_MAX)) ? PW'(PEND_MAX)
                                                : w_sum[PW-1:0];

    assign w_synced   = (r_pend == '0);
    assign w_eq_pc    = (i_dut_pc == i_ref_pc);
    assign w_eq       = w_eq_pc && w_eq_rf;
    assign w_mismatch = (w_synced && !w_eq) || w_proto;
    assign w_stall_clr = (i_dut_commit_cnt != '0) || w_hold;

    assign o_ref_step        = w_step;
    assign o_dut_hold        = w_hold;
    assign o_incorrect       = rst_n && (r_err || w_mismatch);
    assign o_same_init_state = r_init ? (w_eq && i_init_mem_same) : 1'b1;
    assign o_stalled_cycle   = r_stall;
    assign o_live            = r_stall < STW'(STALL_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_err   <= 1'b0;
            r_init  <= 1'b1;
            r_stall <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_init <= 1'b0;
            if (w_mismatch) r_err <= 1'b1;
            if (w_stall_clr)
                r_stall <= '0;
            else if (r_stall != STW'(STALL_LIMIT))
                r_stall <= r_stall + 1'b1;
        end
    end

`ifdef CHECKER_MISMATCH_LOG_EN
    logic [CYC_W-1:0] r_cyc;
    logic [1:0]       r_kind;
    logic [IW-1:0]    r_reg;
    logic [CYC_W-1:0] r_mcyc;
    logic [1:0]       w_kind;

    assign w_kind = w_proto  ? MISMATCH_PROTO :
                    !w_eq_pc ? MISMATCH_PC    : MISMATCH_RF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc  <= '0;
            r_kind <= MISMATCH_NONE;
            r_reg  <= '0;
            r_mcyc <= '0;
        end else begin
            if (!(&r_cyc)) r_cyc <= r_cyc + 1'b1;
            if (w_mismatch && !r_err) begin
                r_kind <= w_kind;
                r_reg  <= w_diff_idx;
                r_mcyc <= r_cyc;
            end
        end
    end

    assign o_mismatch_kind  = r_kind;
    assign o_mismatch_reg   = r_reg;
    assign o_mismatch_cycle = r_mcyc;
`else
    logic w_unused_diff;
    assign w_unused_diff    = ^w_diff_idx;
    assign o_mismatch_kind  = MISMATCH_NONE;
    assign o_mismatch_reg   = '0;
    assign o_mismatch_cycle = '0;
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: a count-indexed program model drives
// both DUT and ISA sides; ISA steps follow the checker's ref_step.
module tb_lockstep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cnt = '0;
    logic        hold;
    logic [7:0]  dut_pc;
    logic [31:0] dut_rf;
    logic        ref_step;
    logic [7:0]  ref_pc;
    logic [31:0] ref_rf;
    logic        mem_same = 1'b1;
    logic        same_init;
    logic        incorrect;
    logic        live;
    logic [3:0]  stalled;
    logic [1:0]  kind;
    logic [1:0]  mreg;
    logic [15:0] mcyc;

    int dut_n = 0;
    int ref_n = 0;
    logic [7:0]  pc_x = '0;
    logic [31:0] rf_x = '0;
    int tb_cyc = 0;
    int checks = 0;
    int passed = 0;

`ifdef CHECKER_MISMATCH_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    always #5 clk = ~clk;

    lockstep_checker u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_dut_commit_cnt  (cnt),
        .o_dut_hold        (hold),
        .i_dut_pc          (dut_pc),
        .i_dut_rf          (dut_rf),
        .o_ref_step        (ref_step),
        .i_ref_pc          (ref_pc),
        .i_ref_rf          (ref_rf),
        .i_init_mem_same   (mem_same),
        .o_same_init_state (same_init),
        .o_incorrect       (incorrect),
        .o_live            (live),
        .o_stalled_cycle   (stalled),
        .o_mismatch_kind   (kind),
        .o_mismatch_reg    (mreg),
        .o_mismatch_cycle  (mcyc)
    );

    function automatic logic [31:0] rf_of(input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(n * (i + 1) + i);
        return r;
    endfunction

    assign dut_pc = 8'(dut_n * 4);
    assign ref_pc = 8'(ref_n * 4) ^ pc_x;
    assign dut_rf = rf_of(dut_n);
    assign ref_rf = rf_of(ref_n) ^ rf_x;

    always @(posedge clk) begin
        if (!rst_n) begin
            dut_n <= 0;
            ref_n <= 0;
        end else begin
            dut_n <= dut_n + int'(cnt);
            ref_n <= ref_n + int'(ref_step);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst_n) tb_cyc = 0;
        else tb_cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cnt = '0;
        pc_x = '0;
        rf_x = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ref_step !== 1'b0) $display("FAIL rst_step got=%0b want=0", ref_step); else passed++;
        checks++; if (hold !== 1'b0) $display("FAIL rst_hold got=%0b want=0", hold); else passed++;
        checks++; if (live !== 1'b1) $display("FAIL rst_live got=%0b want=1", live); else passed++;
        checks++; if (stalled !== 4'd0) $display("FAIL rst_stall got=%0d want=0", stalled); else passed++;
        checks++; if (kind !== 2'd0) $display("FAIL rst_kind got=%0d want=0", kind); else passed++;
        rf_x = 32'h1;
        #1;
        checks++; if (incorrect !== 1'b0) $display("FAIL rst_incorrect got=%0b want=0", incorrect); else passed++;
        rf_x = '0;
        rst_n = 1'b1;
        #1;
        checks++; if (same_init !== 1'b1) $display("FAIL init_same got=%0b want=1", same_init); else passed++;
        mem_same = 1'b0;
        #1;
        checks++; if (same_init !== 1'b0) $display("FAIL init_memdiff got=%0b want=0", same_init); else passed++;
        mem_same = 1'b1;
        tick();
        mem_same = 1'b0;
        #1;
        checks++; if (same_init !== 1'b1) $display("FAIL post_init got=%0b want=1", same_init); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL post_init_inc got=%0b want=0", incorrect); else passed++;
        mem_same = 1'b1;
    endtask

    task automatic test_retire();
        cnt = 2'd2;
        #1;
        checks++; if (ref_step !== 1'b0) $display("FAIL ret_step0 got=%0b want=0", ref_step); else passed++;
        tick();
        cnt = 2'd0;
        #1;
        checks++; if (ref_step !== 1'b1) $display("FAIL ret_step1 got=%0b want=1", ref_step); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL ret_inc1 got=%0b want=0", incorrect); else passed++;
        tick();
        checks++; if (ref_step !== 1'b1) $display("FAIL ret_step2 got=%0b want=1", ref_step); else passed++;
        tick();
        checks++; if (ref_step !== 1'b0) $display("FAIL ret_synced got=%0b want=0", ref_step); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL ret_inc got=%0b want=0", incorrect); else passed++;
    endtask

    task automatic test_back_to_back();
        cnt = 2'd2;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++; if (hold !== 1'b0) $display("FAIL b2b_hold%0d got=%0b want=0", i, hold); else passed++;
            tick();
        end
        cnt = 2'd0;
        #1;
        checks++; if (hold !== 1'b1) $display("FAIL b2b_hold_full got=%0b want=1", hold); else passed++;
        tick();
        checks++; if (hold !== 1'b0) $display("FAIL b2b_hold_drop got=%0b want=0", hold); else passed++;
        cnt = 2'd1;
        #1;
        checks++; if (hold !== 1'b0) $display("FAIL b2b_same_hold got=%0b want=0", hold); else passed++;
        tick();
        cnt = 2'd0;
        #1;
        checks++; if (hold !== 1'b0) $display("FAIL b2b_net0 got=%0b want=0", hold); else passed++;
        for (int i = 0; i < 7; i++) begin
            checks++; if (ref_step !== 1'b1) $display("FAIL b2b_drain%0d got=%0b want=1", i, ref_step); else passed++;
            tick();
        end
        checks++; if (ref_step !== 1'b0) $display("FAIL b2b_empty got=%0b want=0", ref_step); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL b2b_inc got=%0b want=0", incorrect); else passed++;
    endtask

    task automatic test_stall();
        cnt = 2'd1;
        tick();
        cnt = 2'd0;
        #1;
        checks++; if (stalled !== 4'd0) $display("FAIL stall_clr got=%0d want=0", stalled); else passed++;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (stalled !== 4'd9) $display("FAIL stall9 got=%0d want=9", stalled); else passed++;
        checks++; if (live !== 1'b1) $display("FAIL live9 got=%0b want=1", live); else passed++;
        tick();
        checks++; if (stalled !== 4'd10) $display("FAIL stall10 got=%0d want=10", stalled); else passed++;
        checks++; if (live !== 1'b0) $display("FAIL live10 got=%0b want=0", live); else passed++;
        tick();
        checks++; if (stalled !== 4'd10) $display("FAIL stall_sat got=%0d want=10", stalled); else passed++;
        cnt = 2'd1;
        tick();
        cnt = 2'd0;
        #1;
        checks++; if (stalled !== 4'd0) $display("FAIL stall_rst got=%0d want=0", stalled); else passed++;
        checks++; if (live !== 1'b1) $display("FAIL live_back got=%0b want=1", live); else passed++;
        tick();
        tick();
    endtask

    task automatic test_rf_mismatch();
        int exp_cyc;
        rf_x = 32'h0101_0000;
        #1;
        checks++; if (incorrect !== 1'b1) $display("FAIL rf_inc_now got=%0b want=1", incorrect); else passed++;
        exp_cyc = tb_cyc;
        tick();
        rf_x = '0;
        #1;
        checks++; if (incorrect !== 1'b1) $display("FAIL rf_sticky got=%0b want=1", incorrect); else passed++;
        checks++; if (kind !== (LOG ? 2'd2 : 2'd0)) $display("FAIL rf_kind got=%0d want=%0d", kind, LOG ? 2 : 0); else passed++;
        checks++; if (mreg !== (LOG ? 2'd2 : 2'd0)) $display("FAIL rf_reg got=%0d want=%0d", mreg, LOG ? 2 : 0); else passed++;
        checks++; if (mcyc !== (LOG ? 16'(exp_cyc) : 16'd0)) $display("FAIL rf_cyc got=%0d want=%0d", mcyc, LOG ? exp_cyc : 0); else passed++;
        pc_x = 8'h10;
        tick();
        pc_x = '0;
        #1;
        checks++; if (kind !== (LOG ? 2'd2 : 2'd0)) $display("FAIL rf_first_kept got=%0d want=%0d", kind, LOG ? 2 : 0); else passed++;
        tick();
        checks++; if (incorrect !== 1'b1) $display("FAIL rf_forever got=%0b want=1", incorrect); else passed++;
    endtask

    task automatic test_pc_priority();
        pc_x = 8'h04;
        rf_x = 32'h0000_ff00;
        #1;
        checks++; if (incorrect !== 1'b1) $display("FAIL pc_inc got=%0b want=1", incorrect); else passed++;
        tick();
        pc_x = '0;
        rf_x = '0;
        #1;
        checks++; if (kind !== (LOG ? 2'd1 : 2'd0)) $display("FAIL pc_kind got=%0d want=%0d", kind, LOG ? 1 : 0); else passed++;
        checks++; if (mreg !== (LOG ? 2'd1 : 2'd0)) $display("FAIL pc_reg got=%0d want=%0d", mreg, LOG ? 1 : 0); else passed++;
    endtask

    task automatic test_protocol();
        cnt = 2'd2;
        for (int i = 0; i < 7; i++) tick();
        cnt = 2'd0;
        #1;
        checks++; if (hold !== 1'b1) $display("FAIL pr_hold got=%0b want=1", hold); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL pr_pre_inc got=%0b want=0", incorrect); else passed++;
        cnt = 2'd2;
        #1;
        checks++; if (incorrect !== 1'b1) $display("FAIL pr_inc got=%0b want=1", incorrect); else passed++;
        tick();
        cnt = 2'd0;
        #1;
        checks++; if (kind !== (LOG ? 2'd3 : 2'd0)) $display("FAIL pr_kind got=%0d want=%0d", kind, LOG ? 3 : 0); else passed++;
        checks++; if (hold !== 1'b1) $display("FAIL pr_hold2 got=%0b want=1", hold); else passed++;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (ref_step !== 1'b1) $display("FAIL pr_drain7 got=%0b want=1", ref_step); else passed++;
        tick();
        checks++; if (ref_step !== 1'b0) $display("FAIL pr_capped got=%0b want=0", ref_step); else passed++;
        checks++; if (incorrect !== 1'b1) $display("FAIL pr_sticky got=%0b want=1", incorrect); else passed++;
    endtask

    task automatic test_reset_midrun();
        cnt = 2'd2;
        tick();
        cnt = 2'd0;
        #1;
        checks++; if (ref_step !== 1'b1) $display("FAIL mid_step got=%0b want=1", ref_step); else passed++;
        rst_n = 1'b0;
        tick();
        checks++; if (ref_step !== 1'b0) $display("FAIL mid_rst_step got=%0b want=0", ref_step); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL mid_rst_inc got=%0b want=0", incorrect); else passed++;
        checks++; if (kind !== 2'd0) $display("FAIL mid_rst_kind got=%0d want=0", kind); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (ref_step !== 1'b0) $display("FAIL mid_carry got=%0b want=0", ref_step); else passed++;
        checks++; if (incorrect !== 1'b0) $display("FAIL mid_inc got=%0b want=0", incorrect); else passed++;
    endtask

    initial begin
        test_reset();
        test_retire();
        test_back_to_back();
        test_stall();
        test_rf_mismatch();
        do_reset();
        test_pc_priority();
        do_reset();
        test_protocol();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
